// File: rtl/c64_dma_arbiter.sv
// Two-master DMA arbiter for the C64 expansion port: grants one master at a time,
// sequences dma/bus strobes against phi2 and BA, and returns read data with a 1-clk ack.
module c64_dma_arbiter #(
  parameter int BURST_MAX  = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_phi2,
  input  logic        i_ba,
  input  logic [7:0]  i_bus_do,
  output logic        o_dma,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_di,
  output logic        o_bus_we,
  input  logic        i_a_req,
  input  logic [15:0] i_a_addr,
  input  logic        i_a_we,
  input  logic [7:0]  i_a_wdata,
  output logic        o_a_ack,
  output logic [7:0]  o_a_rdata,
  input  logic        i_b_req,
  input  logic [15:0] i_b_addr,
  input  logic        i_b_we,
  input  logic [7:0]  i_b_wdata,
  output logic        o_b_ack,
  output logic [7:0]  o_b_rdata,
  output logic        o_grant
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_XFER, S_HOLD, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_phi2_q;
  logic          r_dma, r_bus_we, r_a_ack, r_b_ack, r_grant;
  logic [15:0]   r_bus_addr;
  logic [7:0]    r_bus_di, r_a_rdata, r_b_rdata;
  logic [BW-1:0] r_burst;
  logic [GW-1:0] r_gap;

  logic w_rise, w_fall, w_win_req, w_arb_win;
  logic w_arb, w_latch, w_done, w_release;

  assign w_rise    = i_phi2 & ~r_phi2_q;
  assign w_fall    = ~i_phi2 & r_phi2_q;
  assign w_win_req = r_grant ? i_b_req : i_a_req;
  // Tie goes to the port that did not hold the last grant.
  assign w_arb_win = (i_a_req & i_b_req) ? ~r_grant : ~i_a_req;

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && (i_a_req || i_b_req)) begin
          w_arb       = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (w_rise) begin
          if (!w_win_req) begin
            w_release   = 1'b1;
            w_state_nxt = S_GAP;
          end else if (i_ba) begin
            w_latch     = 1'b1;
            w_state_nxt = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (w_fall) begin
          w_done      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_rise) begin
          if (!w_win_req || (r_burst == BW'(BURST_MAX))) begin
            w_release   = 1'b1;
            w_state_nxt = S_GAP;
          end else if (i_ba) begin
            w_latch     = 1'b1;
            w_state_nxt = S_XFER;
          end
        end
      end
      S_GAP: begin
        if (w_fall && ((r_gap + 1'b1) == GW'(GAP_CYCLES)))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_phi2_q   <= 1'b0;
      r_dma      <= 1'b0;
      r_bus_addr <= '0;
      r_bus_di   <= '0;
      r_bus_we   <= 1'b0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_grant    <= 1'b1;
      r_burst    <= '0;
      r_gap      <= '0;
    end else begin
      r_phi2_q <= i_phi2;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      if (w_arb) begin
        r_grant <= w_arb_win;
        r_dma   <= 1'b1;
        r_burst <= '0;
      end
      if (w_latch) begin
        r_bus_addr <= r_grant ? i_b_addr  : i_a_addr;
        r_bus_we   <= r_grant ? i_b_we    : i_a_we;
        r_bus_di   <= r_grant ? i_b_wdata : i_a_wdata;
      end
      if (w_done) begin
        if (!r_bus_we) begin
          if (r_grant) r_b_rdata <= i_bus_do;
          else         r_a_rdata <= i_bus_do;
        end
        if (r_grant) r_b_ack <= 1'b1;
        else         r_a_ack <= 1'b1;
        r_burst <= r_burst + 1'b1;
      end
      // Address and write data stay on the bus after release; only the strobes drop.
      if (w_release) begin
        r_dma    <= 1'b0;
        r_bus_we <= 1'b0;
        r_gap    <= '0;
      end
      if ((r_state == S_GAP) && w_fall)
        r_gap <= r_gap + 1'b1;
    end
  end

  assign o_dma      = r_dma;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_di   = r_bus_di;
  assign o_bus_we   = r_bus_we;
  assign o_a_ack    = r_a_ack;
  assign o_b_ack    = r_b_ack;
  assign o_a_rdata  = r_a_rdata;
  assign o_b_rdata  = r_b_rdata;
  assign o_grant    = r_grant;

endmodule

// File: tb/tb_c64_dma_arbiter.sv
// Scoreboard bench for c64_dma_arbiter: masters push expected transfers, the ack monitor
// pops and compares; scenario tasks check grant order, burst limits, stalls and reset.
module tb_c64_dma_arbiter;

  localparam int BMAX = 16;
  localparam int GAP  = 1;

  logic        clk = 1'b0, reset = 1'b1, phi2 = 1'b0, ba = 1'b1;
  logic [7:0]  bus_do;
  logic        o_dma, o_bus_we, o_a_ack, o_b_ack, o_grant;
  logic [15:0] o_bus_addr;
  logic [7:0]  o_bus_di, o_a_rdata, o_b_rdata;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } xfer_t;

  xfer_t sb_a[$], sb_b[$];
  int    n_checks = 0, n_pass = 0;
  int    ack_cnt_a = 0, ack_cnt_b = 0, grant_cnt = 0, acks_this = 0, falls_low = 0;
  int    burst_log[$], gap_log[$], ack_order[$];
  logic  prev_dma = 1'b0, prev_phi2 = 1'b0;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return (a == 16'hD020) ? 8'h0E : (a[7:0] ^ a[15:8] ^ 8'h5A);
  endfunction

  assign bus_do = mem_rd(o_bus_addr);

  c64_dma_arbiter #(.BURST_MAX(BMAX), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_reset(reset), .i_phi2(phi2), .i_ba(ba), .i_bus_do(bus_do),
    .o_dma(o_dma), .o_bus_addr(o_bus_addr), .o_bus_di(o_bus_di), .o_bus_we(o_bus_we),
    .i_a_req(a_req), .i_a_addr(a_addr), .i_a_we(a_we), .i_a_wdata(a_wdata),
    .o_a_ack(o_a_ack), .o_a_rdata(o_a_rdata),
    .i_b_req(b_req), .i_b_addr(b_addr), .i_b_we(b_we), .i_b_wdata(b_wdata),
    .o_b_ack(o_b_ack), .o_b_rdata(o_b_rdata),
    .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  // phi2: 4 clk high / 4 clk low, changing just after a rising clk edge.
  initial begin
    forever begin
      repeat (4) @(posedge clk);
      #1 phi2 = ~phi2;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Ack monitor: scoreboard pop/compare plus grant/burst/gap bookkeeping.
  always @(negedge clk) begin
    xfer_t      e;
    logic       ack;
    logic [7:0] rd;
    if (o_a_ack || o_b_ack) begin
      n_checks++;
      if (o_a_ack && o_b_ack) $display("FAIL dual_ack: a_ack=1 b_ack=1, required at most one");
      else n_pass++;
    end
    for (int p = 0; p < 2; p++) begin
      ack = (p == 1) ? o_b_ack : o_a_ack;
      rd  = (p == 1) ? o_b_rdata : o_a_rdata;
      if (ack) begin
        n_checks++;
        if ((p == 1 && sb_b.size() == 0) || (p == 0 && sb_a.size() == 0)) begin
          $display("FAIL unexpected_ack port %0d: no transfer outstanding", p);
        end else begin
          if (p == 1) e = sb_b.pop_front();
          else        e = sb_a.pop_front();
          if (o_grant !== (p == 1) || o_bus_addr !== e.addr || o_bus_we !== e.we ||
              (e.we && o_bus_di !== e.wdata) || (!e.we && rd !== e.rdata))
            $display("FAIL sb_port%0d: grant=%0b addr=%h we=%0b di=%h rd=%h, required grant=%0d addr=%h we=%0b di=%h rd=%h",
                     p, o_grant, o_bus_addr, o_bus_we, o_bus_di, rd, p, e.addr, e.we, e.wdata, e.rdata);
          else n_pass++;
        end
        ack_order.push_back(p);
        acks_this++;
        if (p == 1) ack_cnt_b++;
        else        ack_cnt_a++;
      end
    end
    if (!phi2 && prev_phi2 && !o_dma) falls_low++;
    if (o_dma && !prev_dma) begin
      grant_cnt++;
      gap_log.push_back(falls_low);
      falls_low = 0;
    end
    if (!o_dma && prev_dma) begin
      burst_log.push_back(acks_this);
      acks_this = 0;
    end
    prev_dma  = o_dma;
    prev_phi2 = phi2;
  end

  task automatic clear_logs();
    burst_log.delete(); gap_log.delete(); ack_order.delete();
    ack_cnt_a = 0; ack_cnt_b = 0; grant_cnt = 0; acks_this = 0; falls_low = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sig(input int which, input logic [15:0] addr, input int budget,
                          input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (which)
        0: ok = (o_dma === 1'b1);
        1: ok = (o_dma === 1'b0);
        2: ok = (o_a_ack === 1'b1);
        3: ok = (o_b_ack === 1'b1);
        4: ok = (o_bus_addr === addr) && (o_dma === 1'b1);
        default: ok = 1'b1;
      endcase
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL timeout_%s: condition not seen within %0d clks", name, budget);
    end
  endtask

  task automatic run_master(input int p, input int n, input logic [15:0] base, input logic we);
    xfer_t e;
    bit    ok;
    for (int i = 0; i < n; i++) begin
      e.addr  = base + 16'(i);
      e.we    = we;
      e.wdata = 8'(i) ^ 8'hA5;
      e.rdata = mem_rd(e.addr);
      if (p == 0) begin
        sb_a.push_back(e);
        a_addr = e.addr; a_we = we; a_wdata = e.wdata; a_req = 1'b1;
      end else begin
        sb_b.push_back(e);
        b_addr = e.addr; b_we = we; b_wdata = e.wdata; b_req = 1'b1;
      end
      wait_sig((p == 0) ? 2 : 3, 16'h0, 400, "master_ack", ok);
      if (!ok) break;
    end
    if (p == 0) a_req = 1'b0;
    else        b_req = 1'b0;
  endtask

  task automatic test_reset();
    settle(3);
    n_checks++;
    if (o_dma !== 1'b0 || o_bus_we !== 1'b0) $display("FAIL reset_strobes: dma=%b we=%b, required 0 0", o_dma, o_bus_we);
    else n_pass++;
    n_checks++;
    if (o_bus_addr !== 16'h0 || o_bus_di !== 8'h0) $display("FAIL reset_bus: addr=%h di=%h, required 0000 00", o_bus_addr, o_bus_di);
    else n_pass++;
    n_checks++;
    if (o_a_ack !== 1'b0 || o_b_ack !== 1'b0 || o_a_rdata !== 8'h0 || o_b_rdata !== 8'h0)
      $display("FAIL reset_ports: acks=%b%b rdata=%h/%h, required 00 00/00", o_a_ack, o_b_ack, o_a_rdata, o_b_rdata);
    else n_pass++;
    n_checks++;
    if (o_grant !== 1'b1) $display("FAIL reset_grant: grant=%b, required 1", o_grant);
    else n_pass++;
    reset = 1'b0;
    settle(4);
  endtask

  task automatic test_single_read();
    xfer_t e;
    bit    ok;
    clear_logs();
    e.addr = 16'hD020; e.we = 1'b0; e.wdata = 8'h00; e.rdata = 8'h0E;
    sb_a.push_back(e);
    a_addr = 16'hD020; a_we = 1'b0; a_req = 1'b1;
    wait_sig(0, 16'h0, 40, "single_dma_up", ok);
    n_checks++;
    if (phi2 !== 1'b0 || o_grant !== 1'b0) $display("FAIL single_grant_at_fall: phi2=%b grant=%b, required 0 0", phi2, o_grant);
    else n_pass++;
    wait_sig(2, 16'h0, 40, "single_ack", ok);
    a_req = 1'b0;
    n_checks++;
    if (o_a_rdata !== 8'h0E) $display("FAIL single_rdata: got %h, required 0E", o_a_rdata);
    else n_pass++;
    wait_sig(1, 16'h0, 40, "single_dma_down", ok);
    n_checks++;
    if (phi2 !== 1'b1 || o_bus_we !== 1'b0) $display("FAIL single_release_at_rise: phi2=%b we=%b, required 1 0", phi2, o_bus_we);
    else n_pass++;
    n_checks++;
    if (o_bus_addr !== 16'hD020 || o_a_rdata !== 8'h0E || ack_cnt_a != 1)
      $display("FAIL single_hold: addr=%h rdata=%h acks=%0d, required D020 0E 1", o_bus_addr, o_a_rdata, ack_cnt_a);
    else n_pass++;
    settle(24);
  endtask

  task automatic test_tie();
    bit ok;
    reset = 1'b1; settle(2); reset = 1'b0; settle(2);
    clear_logs();
    fork
      run_master(0, 1, 16'h1000, 1'b0);
      run_master(1, 1, 16'h2000, 1'b0);
    join
    wait_sig(1, 16'h0, 40, "tie_dma_down", ok);
    settle(4);
    n_checks++;
    if (ack_order.size() != 2 || ack_order[0] != 0 || ack_order[1] != 1)
      $display("FAIL tie_order: %0d acks, first port %0d, required 2 acks A then B",
               ack_order.size(), (ack_order.size() > 0) ? ack_order[0] : -1);
    else n_pass++;
    n_checks++;
    if (grant_cnt != 2) $display("FAIL tie_grants: got %0d, required 2", grant_cnt);
    else n_pass++;
    n_checks++;
    if (gap_log.size() != 2 || gap_log[1] != GAP + 1)
      $display("FAIL tie_gap: entries=%0d falls=%0d, required 2 entries, %0d falls", gap_log.size(),
               (gap_log.size() > 1) ? gap_log[1] : -1, GAP + 1);
    else n_pass++;
    settle(24);
  endtask

  task automatic test_burst();
    bit ok;
    clear_logs();
    run_master(1, 40, 16'h0400, 1'b1);
    wait_sig(1, 16'h0, 40, "burst_dma_down", ok);
    settle(4);
    n_checks++;
    if (burst_log.size() != 3 || burst_log[0] != 16 || burst_log[1] != 16 || burst_log[2] != 8)
      $display("FAIL burst_split: %0d grants, first %0d, required 3 grants 16/16/8",
               burst_log.size(), (burst_log.size() > 0) ? burst_log[0] : -1);
    else n_pass++;
    n_checks++;
    if (grant_cnt != 3 || ack_cnt_b != 40) $display("FAIL burst_counts: grants=%0d acks=%0d, required 3 40", grant_cnt, ack_cnt_b);
    else n_pass++;
    n_checks++;
    if (gap_log.size() != 3 || gap_log[1] != GAP + 1 || gap_log[2] != GAP + 1)
      $display("FAIL burst_gap: entries=%0d, required 3 with %0d falls between grants", gap_log.size(), GAP + 1);
    else n_pass++;
    settle(24);
  endtask

  task automatic test_ba_stall();
    xfer_t e;
    bit    ok, bad;
    clear_logs();
    ba = 1'b0;
    e.addr = 16'hC000; e.we = 1'b1; e.wdata = 8'h55; e.rdata = mem_rd(16'hC000);
    sb_a.push_back(e);
    a_addr = 16'hC000; a_we = 1'b1; a_wdata = 8'h55; a_req = 1'b1;
    wait_sig(0, 16'h0, 40, "stall_dma_up", ok);
    bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (o_bus_we !== 1'b0 || o_a_ack !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL stall_no_xfer: write strobe or ack seen while ba=0, required none");
    else n_pass++;
    ba = 1'b1;
    wait_sig(2, 16'h0, 40, "stall_ack", ok);
    a_req = 1'b0;
    wait_sig(1, 16'h0, 40, "stall_dma_down", ok);
    settle(24);
    n_checks++;
    if (ack_cnt_a != 1 || ack_cnt_b != 0) $display("FAIL stall_acks: a=%0d b=%0d, required 1 0", ack_cnt_a, ack_cnt_b);
    else n_pass++;
  endtask

  task automatic test_drop_arm();
    bit ok;
    clear_logs();
    a_addr = 16'h3000; a_we = 1'b0; a_req = 1'b1;
    wait_sig(0, 16'h0, 40, "drop_dma_up", ok);
    a_req = 1'b0;
    wait_sig(1, 16'h0, 20, "drop_dma_down", ok);
    n_checks++;
    if (phi2 !== 1'b1 || o_bus_we !== 1'b0) $display("FAIL drop_release_at_rise: phi2=%b we=%b, required 1 0", phi2, o_bus_we);
    else n_pass++;
    settle(24);
    n_checks++;
    if (ack_cnt_a + ack_cnt_b != 0) $display("FAIL drop_no_ack: got %0d acks, required 0", ack_cnt_a + ack_cnt_b);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    a_addr = 16'h5000; a_we = 1'b0; a_req = 1'b1;
    wait_sig(4, 16'h5000, 40, "mid_latch", ok);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (o_dma !== 1'b0 || o_bus_addr !== 16'h0 || o_grant !== 1'b1 || o_a_ack !== 1'b0)
      $display("FAIL mid_reset_async: dma=%b addr=%h grant=%b ack=%b, required 0 0000 1 0", o_dma, o_bus_addr, o_grant, o_a_ack);
    else n_pass++;
    a_req = 1'b0;
    settle(3);
    reset = 1'b0;
    settle(24);
    n_checks++;
    if (ack_cnt_a + ack_cnt_b != 0 || o_a_rdata !== 8'h00)
      $display("FAIL mid_no_ack: acks=%0d rdata=%h, required 0 00", ack_cnt_a + ack_cnt_b, o_a_rdata);
    else n_pass++;
    clear_logs();
    run_master(0, 1, 16'h1234, 1'b0);
    wait_sig(1, 16'h0, 40, "mid_dma_down", ok);
    n_checks++;
    if (ack_cnt_a != 1 || o_a_rdata !== mem_rd(16'h1234))
      $display("FAIL mid_recover: acks=%0d rdata=%h, required 1 %h", ack_cnt_a, o_a_rdata, mem_rd(16'h1234));
    else n_pass++;
    settle(24);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_burst();
    test_ba_stall();
    test_drop_arm();
    test_reset_mid();
    n_checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0)
      $display("FAIL sb_drain: %0d/%0d transfers never acked, required 0/0", sb_a.size(), sb_b.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
